vga_timing_core: RTL and testbench

//  Pixel-timing generator directly upstream of the VGA control/ROM stage.

---
 rtl/vga_timing_core.sv | 132 +++++++++++++
 tb/tb_vga_timing_core.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_core.sv
// VGA pixel-timing generator: column/row counters, registered sync/active decode,
// active-pixel coordinates, line/frame strobes and a frame counter, gated by a pixel enable.
module vga_timing_core #(
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int H_ACT    = 800,
  parameter int H_FP     = 56,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter int V_ACT    = 600,
  parameter int V_FP     = 37,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [10:0] c1,
  output logic [10:0] c2,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

  // Boundaries are 12 bits wide so an active window ending exactly at 2048 still compares correctly.
  localparam logic [11:0] H_LAST      = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST      = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_SYNC_END  = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_END  = 12'(V_SYNC);
  localparam logic [11:0] H_ACT_BEG   = 12'(H_SYNC + H_BP);
  localparam logic [11:0] V_ACT_BEG   = 12'(V_SYNC + V_BP);
  localparam logic [11:0] H_ACT_END   = 12'(H_SYNC + H_BP + H_ACT);
  localparam logic [11:0] V_ACT_END   = 12'(V_SYNC + V_BP + V_ACT);

  logic [10:0] c1_q, c1_d;
  logic [10:0] c2_q, c2_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic [11:0] c1_ext, c2_ext;
  logic        h_wrap, v_wrap, h_act, v_act;

  assign c1_ext = {1'b0, c1_q};
  assign c2_ext = {1'b0, c2_q};
  assign h_wrap = (c1_ext == H_LAST);
  assign v_wrap = (c2_ext == V_LAST);
  assign h_act  = (c1_ext >= H_ACT_BEG) && (c1_ext < H_ACT_END);
  assign v_act  = (c2_ext >= V_ACT_BEG) && (c2_ext < V_ACT_END);

  always_comb begin
    // NOTE: every _d gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    c1_d          = c1_q;
    c2_d          = c2_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    x_d           = x_q;
    y_d           = y_q;
    frame_cnt_d   = frame_cnt_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (en) begin
      c1_d = h_wrap ? 11'd0 : c1_q + 11'd1;
      if (h_wrap) begin
        c2_d = v_wrap ? 11'd0 : c2_q + 11'd1;
        if (v_wrap) frame_cnt_d = frame_cnt_q + 16'd1;
      end

      // Decode uses the pre-increment position, giving one enabled cycle of latency.
      hsync_d       = (c1_ext < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = (c2_ext < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
      de_d          = h_act && v_act;
      x_d           = (h_act && v_act) ? c1_q - H_ACT_BEG[10:0] : 11'd0;
      y_d           = (h_act && v_act) ? c2_q - V_ACT_BEG[10:0] : 11'd0;
      line_start_d  = (c1_q == 11'd0);
      frame_start_d = (c1_q == 11'd0) && (c2_q == 11'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c1_q          <= 11'd0;
      c2_q          <= 11'd0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      de_q          <= 1'b0;
      x_q           <= 11'd0;
      y_q           <= 11'd0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      c1_q          <= c1_d;
      c2_q          <= c2_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign c1          = c1_q;
  assign c2          = c2_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_core.sv
// Bench for vga_timing_core: three timing configurations driven together and compared every clock
// against a position-arithmetic reference model, plus per-scenario counts and boundary checks.
module tb_vga_timing_core;

  typedef struct {
    int hs, hb, ha, hf, vs, vb, va, vf;
    bit pol;
  } cfg_t;

  typedef struct packed {
    logic [10:0] c1;
    logic [10:0] c2;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [10:0] x;
    logic [10:0] y;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  logic [10:0] c1_o [3];
  logic [10:0] c2_o [3];
  logic        hsync_o [3];
  logic        vsync_o [3];
  logic        de_o [3];
  logic [10:0] x_o [3];
  logic [10:0] y_o [3];
  logic        ls_o [3];
  logic        fs_o [3];
  logic [15:0] fc_o [3];

  cfg_t cfgs [3];
  int   n;        // enabled edges since the last reset
  bit   last_en;  // whether the most recent edge was enabled
  int   errors = 0;
  int   checks = 0;
  int   fail_prints = 0;

  always #5 clk = ~clk;

  // Instance 0: default 800x600 timing.
  vga_timing_core u_dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .c1(c1_o[0]), .c2(c2_o[0]), .hsync(hsync_o[0]), .vsync(vsync_o[0]), .de(de_o[0]),
    .x(x_o[0]), .y(y_o[0]), .line_start(ls_o[0]), .frame_start(fs_o[0]), .frame_cnt(fc_o[0])
  );

  // Instance 1: 640x480 with active-high syncs.
  vga_timing_core #(
    .H_SYNC(96), .H_BP(48), .H_ACT(640), .H_FP(16),
    .V_SYNC(2), .V_BP(33), .V_ACT(480), .V_FP(10), .SYNC_POL(1'b1)
  ) u_dut_vga (
    .clk(clk), .rst_n(rst_n), .en(en),
    .c1(c1_o[1]), .c2(c2_o[1]), .hsync(hsync_o[1]), .vsync(vsync_o[1]), .de(de_o[1]),
    .x(x_o[1]), .y(y_o[1]), .line_start(ls_o[1]), .frame_start(fs_o[1]), .frame_cnt(fc_o[1])
  );

  // Instance 2: tiny raster (13 x 9) so whole frames fit in a short run.
  vga_timing_core #(
    .H_SYNC(3), .H_BP(2), .H_ACT(6), .H_FP(2),
    .V_SYNC(2), .V_BP(1), .V_ACT(4), .V_FP(2), .SYNC_POL(1'b0)
  ) u_dut_tiny (
    .clk(clk), .rst_n(rst_n), .en(en),
    .c1(c1_o[2]), .c2(c2_o[2]), .hsync(hsync_o[2]), .vsync(vsync_o[2]), .de(de_o[2]),
    .x(x_o[2]), .y(y_o[2]), .line_start(ls_o[2]), .frame_start(fs_o[2]), .frame_cnt(fc_o[2])
  );

  // Expected outputs from raster position: after n enabled pixels the counters sit at pixel n,
  // and the registered decode reflects pixel n-1.
  function automatic obs_t model(input cfg_t c, input int cnt, input bit prev_en);
    obs_t e;
    int ht, vt, p, pc1, pc2;
    bit act;
    ht = c.hs + c.hb + c.ha + c.hf;
    vt = c.vs + c.vb + c.va + c.vf;
    e.c1 = 11'(cnt % ht);
    e.c2 = 11'((cnt / ht) % vt);
    e.fc = 16'((cnt / (ht * vt)) % 65536);
    if (cnt == 0) begin
      e.hsync = !c.pol; e.vsync = !c.pol; e.de = 1'b0;
      e.x = '0; e.y = '0; e.ls = 1'b0; e.fs = 1'b0;
    end else begin
      p   = cnt - 1;
      pc1 = p % ht;
      pc2 = (p / ht) % vt;
      act = (pc1 >= c.hs + c.hb) && (pc1 < c.hs + c.hb + c.ha) &&
            (pc2 >= c.vs + c.vb) && (pc2 < c.vs + c.vb + c.va);
      e.hsync = (pc1 < c.hs) ? c.pol : !c.pol;
      e.vsync = (pc2 < c.vs) ? c.pol : !c.pol;
      e.de    = act;
      e.x     = act ? 11'(pc1 - (c.hs + c.hb)) : 11'd0;
      e.y     = act ? 11'(pc2 - (c.vs + c.vb)) : 11'd0;
      e.ls    = prev_en && (pc1 == 0);
      e.fs    = prev_en && (pc1 == 0) && (pc2 == 0);
    end
    return e;
  endfunction

  task automatic compare_all();
    obs_t e, a;
    for (int i = 0; i < 3; i++) begin
      e = model(cfgs[i], n, last_en);
      a.c1 = c1_o[i]; a.c2 = c2_o[i]; a.hsync = hsync_o[i]; a.vsync = vsync_o[i];
      a.de = de_o[i]; a.x = x_o[i]; a.y = y_o[i]; a.ls = ls_o[i]; a.fs = fs_o[i]; a.fc = fc_o[i];
      checks++;
      if (a !== e) begin
        errors++;
        if (fail_prints < 20) begin
          fail_prints++;
          $display("FAIL model inst%0d n=%0d got c1=%0d c2=%0d hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b fc=%0d want c1=%0d c2=%0d hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b fc=%0d",
                   i, n, a.c1, a.c2, a.hsync, a.vsync, a.de, a.x, a.y, a.ls, a.fs, a.fc,
                   e.c1, e.c2, e.hsync, e.vsync, e.de, e.x, e.y, e.ls, e.fs, e.fc);
        end
      end
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, sample 1 time unit later.
  task automatic tick(input bit r, input bit e);
    rst_n = r;
    en    = e;
    @(posedge clk);
    if (!r) begin
      n = 0;
      last_en = 1'b0;
    end else begin
      if (e) n++;
      last_en = e;
    end
    #1;
    compare_all();
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    checks++;
    if (c1_o[0] !== 11'd0 || c2_o[0] !== 11'd0 || hsync_o[0] !== 1'b1 || vsync_o[0] !== 1'b1 ||
        de_o[0] !== 1'b0 || ls_o[0] !== 1'b0 || fs_o[0] !== 1'b0 || fc_o[0] !== 16'd0) begin
      errors++;
      $display("FAIL reset_default got c1=%0d c2=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d want 0 0 1 1 0 0 0 0",
               c1_o[0], c2_o[0], hsync_o[0], vsync_o[0], de_o[0], ls_o[0], fs_o[0], fc_o[0]);
    end
    checks++;
    if (hsync_o[1] !== 1'b0 || vsync_o[1] !== 1'b0) begin
      errors++;
      $display("FAIL reset_pol_high got hs=%b vs=%b want 0 0", hsync_o[1], vsync_o[1]);
    end
  endtask

  task automatic test_first_line();
    int hs_cnt = 0, ls_cnt = 0;
    bit ls_first = 0, ls_second = 0;
    logic [10:0] c1_end = '0, c2_end = '0;
    tick(1'b0, 1'b1);
    for (int k = 1; k <= 1041; k++) begin
      tick(1'b1, 1'b1);
      if (k <= 1040 && hsync_o[0] === 1'b0) hs_cnt++;
      if (ls_o[0] === 1'b1) begin
        ls_cnt++;
        if (k == 1) ls_first = 1;
        if (k == 1041) ls_second = 1;
      end
      if (k == 1040) begin c1_end = c1_o[0]; c2_end = c2_o[0]; end
    end
    checks++;
    if (hs_cnt != 120) begin
      errors++; $display("FAIL first_line_hsync_width got %0d want 120", hs_cnt);
    end
    checks++;
    if (ls_cnt != 2 || !ls_first || !ls_second) begin
      errors++; $display("FAIL first_line_line_start got count=%0d at1=%0d at1041=%0d want 2 1 1",
                         ls_cnt, ls_first, ls_second);
    end
    checks++;
    if (c1_end !== 11'd0 || c2_end !== 11'd1) begin
      errors++; $display("FAIL first_line_wrap got c1=%0d c2=%0d want 0 1", c1_end, c2_end);
    end
  endtask

  task automatic test_en_pattern();
    int ls_cnt = 0, wide = 0;
    logic prev_ls = 1'b0;
    tick(1'b0, 1'b1);
    for (int k = 0; k < 3 * 1041; k++) begin
      tick(1'b1, (k % 3) == 0);
      if (ls_o[0] === 1'b1) begin
        ls_cnt++;
        if (prev_ls === 1'b1) wide++;
      end
      prev_ls = ls_o[0];
    end
    checks++;
    if (wide != 0 || ls_cnt != 2) begin
      errors++; $display("FAIL en_pattern_pulse got wide=%0d count=%0d want 0 2", wide, ls_cnt);
    end
    checks++;
    if (c1_o[0] !== 11'd1 || c2_o[0] !== 11'd1) begin
      errors++; $display("FAIL en_pattern_pos got c1=%0d c2=%0d want 1 1", c1_o[0], c2_o[0]);
    end
  endtask

  task automatic test_mid_reset();
    tick(1'b0, 1'b1);
    for (int k = 0; k < 1540; k++) tick(1'b1, 1'b1);
    checks++;
    if (c1_o[0] !== 11'd500 || c2_o[0] !== 11'd1) begin
      errors++; $display("FAIL mid_reset_pre got c1=%0d c2=%0d want 500 1", c1_o[0], c2_o[0]);
    end
    tick(1'b0, 1'b1);
    checks++;
    if (c1_o[0] !== 11'd0 || c2_o[0] !== 11'd0 || hsync_o[0] !== 1'b1 || de_o[0] !== 1'b0 ||
        ls_o[0] !== 1'b0 || fc_o[0] !== 16'd0) begin
      errors++; $display("FAIL mid_reset_apply got c1=%0d c2=%0d hs=%b de=%b ls=%b fc=%0d want 0 0 1 0 0 0",
                         c1_o[0], c2_o[0], hsync_o[0], de_o[0], ls_o[0], fc_o[0]);
    end
    tick(1'b1, 1'b1);
    checks++;
    if (c1_o[0] !== 11'd1 || ls_o[0] !== 1'b1) begin
      errors++; $display("FAIL mid_reset_resume got c1=%0d ls=%b want 1 1", c1_o[0], ls_o[0]);
    end
  endtask

  task automatic test_small_frames();
    int de_cnt = 0, vs_cnt = 0, fs_cnt = 0, first_k = -1;
    logic [10:0] fx = '1, fy = '1, lx = '0, ly = '0;
    tick(1'b0, 1'b1);
    for (int k = 1; k <= 3 * 117; k++) begin
      tick(1'b1, 1'b1);
      if (vsync_o[2] === 1'b0) vs_cnt++;
      if (fs_o[2] === 1'b1) fs_cnt++;
      if (k <= 117 && de_o[2] === 1'b1) begin
        de_cnt++;
        if (first_k < 0) begin first_k = k; fx = x_o[2]; fy = y_o[2]; end
        lx = x_o[2]; ly = y_o[2];
      end
    end
    checks++;
    if (de_cnt != 24) begin
      errors++; $display("FAIL tiny_de_count got %0d want 24", de_cnt);
    end
    checks++;
    if (first_k != 45 || fx !== 11'd0 || fy !== 11'd0) begin
      errors++; $display("FAIL tiny_first_de got k=%0d x=%0d y=%0d want 45 0 0", first_k, fx, fy);
    end
    checks++;
    if (lx !== 11'd5 || ly !== 11'd3) begin
      errors++; $display("FAIL tiny_last_de got x=%0d y=%0d want 5 3", lx, ly);
    end
    checks++;
    if (vs_cnt != 78 || fs_cnt != 3 || fc_o[2] !== 16'd3) begin
      errors++; $display("FAIL tiny_frames got vsync=%0d fs=%0d fc=%0d want 78 3 3", vs_cnt, fs_cnt, fc_o[2]);
    end
  endtask

  task automatic test_alt_timing();
    int hs_cnt = 0, de_cnt = 0;
    logic [10:0] fx = '1, fy = '1, c1_last = '0;
    bit seen = 0;
    tick(1'b0, 1'b1);
    for (int k = 1; k <= 36 * 800; k++) begin
      tick(1'b1, 1'b1);
      if (hsync_o[1] === 1'b1) hs_cnt++;
      if (de_o[1] === 1'b1) begin
        de_cnt++;
        if (!seen) begin seen = 1; fx = x_o[1]; fy = y_o[1]; end
      end
      if (k == 799) c1_last = c1_o[1];
    end
    checks++;
    if (hs_cnt != 36 * 96) begin
      errors++; $display("FAIL vga_hsync_high got %0d want %0d", hs_cnt, 36 * 96);
    end
    checks++;
    if (de_cnt != 640 || fx !== 11'd0 || fy !== 11'd0) begin
      errors++; $display("FAIL vga_first_line_de got count=%0d x=%0d y=%0d want 640 0 0", de_cnt, fx, fy);
    end
    checks++;
    if (c1_last !== 11'd799 || c1_o[1] !== 11'd0 || c2_o[1] !== 11'd36) begin
      errors++; $display("FAIL vga_totals got c1@799=%0d c1=%0d c2=%0d want 799 0 36", c1_last, c1_o[1], c2_o[1]);
    end
  endtask

  task automatic test_random();
    tick(1'b0, 1'b1);
    for (int k = 0; k < 2000; k++) begin
      tick($urandom_range(0, 199) != 0, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    cfgs[0] = '{hs: 120, hb: 64, ha: 800, hf: 56, vs: 6, vb: 23, va: 600, vf: 37, pol: 1'b0};
    cfgs[1] = '{hs: 96,  hb: 48, ha: 640, hf: 16, vs: 2, vb: 33, va: 480, vf: 10, pol: 1'b1};
    cfgs[2] = '{hs: 3,   hb: 2,  ha: 6,   hf: 2,  vs: 2, vb: 1,  va: 4,   vf: 2,  pol: 1'b0};
    n = 0;
    last_en = 1'b0;
    rst_n = 1'b0;
    en = 1'b0;

    test_reset();
    test_first_line();
    test_en_pattern();
    test_mid_reset();
    test_small_frames();
    test_alt_timing();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
